// File: rtl/pe_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// pe_accumulator_pkg
//   Shared parameters and types for the PE accumulator stage.
//   - ACC_DATA_WIDTH    : width of partial sums and of the final result.
//   - DEFAULT_CNT_WIDTH : default width of the accumulation-length counter.
//   - acc_state_t       : accumulator control states.
// -----------------------------------------------------------------------------
package pe_accumulator_pkg;

  localparam int ACC_DATA_WIDTH    = 32;
  localparam int DEFAULT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage : pe_accumulator_pkg

// File: rtl/pe_accumulator.sv
// -----------------------------------------------------------------------------
// pe_accumulator
//   Accumulator register stage sitting directly after the MAC adder of a PE.
//   The partial-sum register feeds the adder's second operand, so the adder
//   produces product + partial sum each cycle and this block simply stores the
//   adder output. After a programmed number of accepted sums the last stored
//   value is presented as the result on a valid/ready interface.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               begin a job (honoured in IDLE, or in DONE together
//                       with result_ready for a back-to-back restart)
//   flush               synchronous abort to IDLE; beats every other input
//   num_accumulations   number of sums to accept (latched on start)
//   use_bias, bias      preload bias (1) or zero (0) into the partial sum
//   sum, sum_valid      adder output and its qualifier
//   sum_ready           high in ACCUM only
//   acc_out             partial-sum register, to adder operand 1
//   result, result_valid, result_ready   final value handshake
//   busy                state is not IDLE
// -----------------------------------------------------------------------------
module pe_accumulator
  import pe_accumulator_pkg::*;
#(
  parameter int CNT_WIDTH = pe_accumulator_pkg::DEFAULT_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             flush,
  input  logic [CNT_WIDTH-1:0]             num_accumulations,
  input  logic                             use_bias,
  input  logic signed [ACC_DATA_WIDTH-1:0] bias,
  input  logic signed [ACC_DATA_WIDTH-1:0] sum,
  input  logic                             sum_valid,
  output logic                             sum_ready,
  output logic signed [ACC_DATA_WIDTH-1:0] acc_out,
  output logic signed [ACC_DATA_WIDTH-1:0] result,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic                             busy
);

  acc_state_t                 state_q, state_d;
  logic [ACC_DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_DATA_WIDTH-1:0]  result_q, result_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]       target_q, target_d;

  logic [ACC_DATA_WIDTH-1:0]  preload;
  logic [CNT_WIDTH-1:0]       cnt_inc;
  logic                       start_ok;

  assign preload = use_bias ? bias : '0;

  // cnt never exceeds target (at most 2^CNT_WIDTH-1), so this cannot wrap
  // while a job is in progress.
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  // A start is only honoured when no result is pending: from IDLE, or from
  // DONE in the same cycle the pending result is taken downstream.
  assign start_ok = start && ((state_q == IDLE) ||
                              ((state_q == DONE) && result_ready));

  // NOTE: every signal assigned in this block gets its hold value first, so
  // no path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    target_d = target_q;

    unique case (state_q)
      IDLE: ;  // only start_ok / flush below move us out of IDLE
      ACCUM: begin
        // sum_ready is high throughout ACCUM, so sum_valid alone is a transfer.
        if (sum_valid) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if (cnt_inc == target_q) begin
            result_d = sum;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (result_ready && !start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      acc_d    = preload;
      cnt_d    = '0;
      target_d = num_accumulations;
      if (num_accumulations == '0) begin
        // Zero-length job: the preload itself is the result.
        result_d = preload;
        state_d  = DONE;
      end else begin
        state_d  = ACCUM;
      end
    end

    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // All outputs come straight from registers/state: no sum-to-output path.
  assign sum_ready    = (state_q == ACCUM);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign acc_out      = acc_q;
  assign result       = result_q;

endmodule : pe_accumulator

// File: tb/tb_pe_accumulator.sv
// -----------------------------------------------------------------------------
// tb_pe_accumulator
//   Self-checking bench for pe_accumulator. A job-level model (preload value,
//   count of accepted sums, last accepted sum) predicts results; expected
//   results are queued as stimulus is issued and a monitor pops/compares them
//   whenever a result handshake is about to complete.
// -----------------------------------------------------------------------------
module tb_pe_accumulator;
  import pe_accumulator_pkg::*;

  localparam int W = ACC_DATA_WIDTH;
  localparam int C = DEFAULT_CNT_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [C-1:0]  num_accumulations = '0;
  logic          use_bias = 1'b0;
  logic [W-1:0]  bias = '0;
  logic [W-1:0]  sum = '0;
  logic          sum_valid = 1'b0;
  logic          sum_ready;
  logic [W-1:0]  acc_out;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          busy;

  pe_accumulator #(.CNT_WIDTH(C)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .flush             (flush),
    .num_accumulations (num_accumulations),
    .use_bias          (use_bias),
    .bias              (bias),
    .sum               (sum),
    .sum_valid         (sum_valid),
    .sum_ready         (sum_ready),
    .acc_out           (acc_out),
    .result            (result),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_q[$];

  // Job-level reference model.
  logic [W-1:0] m_acc;
  int           m_cnt;
  int           m_n;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a result leaves the block when valid && ready and no
  // flush overrides the handshake at the coming edge.
  always @(negedge clk) begin
    if (!reset && result_valid && result_ready && !flush) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard: unexpected result %h", result);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("result", result, e);
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic begin_job(input bit ub, input logic [W-1:0] b, input int n, input bit rr);
    start = 1'b1; use_bias = ub; bias = b; num_accumulations = C'(n);
    result_ready = rr;
    @(posedge clk); #1;
    start = 1'b0; result_ready = 1'b0;
    use_bias = 1'b0; bias = '0; num_accumulations = '0;
    m_acc = ub ? b : '0;
    m_cnt = 0;
    m_n   = n;
    if (n == 0) exp_q.push_back(m_acc);
    @(negedge clk);
    check_bit("start_busy", busy, 1'b1);
    check_bit("start_sum_ready", sum_ready, n != 0);
    check_bit("start_result_valid", result_valid, n == 0);
    check("start_acc_out", acc_out, m_acc);
    if (n == 0) check("zero_len_result", result, m_acc);
    @(posedge clk); #1;
  endtask

  task automatic one_cycle(input bit v, input logic [W-1:0] s);
    sum_valid = v; sum = s;
    @(negedge clk);
    check_bit("accum_sum_ready", sum_ready, 1'b1);
    check("accum_acc_out", acc_out, m_acc);
    @(posedge clk); #1;
    sum_valid = 1'b0; sum = '0;
    if (v) begin
      m_acc = s;
      m_cnt++;
      if (m_cnt == m_n) exp_q.push_back(s);
    end
  endtask

  task automatic run_sums(input bit rnd);
    int budget = 200;
    while (m_cnt != m_n && budget > 0) begin
      one_cycle(rnd ? (($urandom % 10) < 7) : 1'b1, $urandom);
      budget--;
    end
    if (m_cnt != m_n) begin
      compared++; mismatched++;
      $display("FAIL run_sums: cycle budget expired, accepted %0d of %0d", m_cnt, m_n);
    end
  endtask

  task automatic check_done();
    @(negedge clk);
    check_bit("done_result_valid", result_valid, 1'b1);
    check_bit("done_sum_ready", sum_ready, 1'b0);
    check_bit("done_busy", busy, 1'b1);
    check("done_acc_out", acc_out, m_acc);
    @(posedge clk); #1;
  endtask

  task automatic collect();
    int w = 0;
    while (!result_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_bit("collect_wait_valid", result_valid, 1'b1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    check_bit("collect_idle_busy", busy, 1'b0);
    check_bit("collect_idle_valid", result_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_sum_ready"}, sum_ready, 1'b0);
    check_bit({tag, "_result_valid"}, result_valid, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check({tag, "_acc_out"}, acc_out, '0);
    check({tag, "_result"}, result, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit           ub;
    logic [W-1:0] b;
    int           n;
    bit           in_done;
    logic [W-1:0] dropped;
    bit           pat[6];

    // Power-on reset.
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Bias 5, three consecutive sums 12, 20, -7.
    begin_job(1'b1, 32'd5, 3, 1'b0);
    one_cycle(1'b1, 32'd12);
    one_cycle(1'b1, 32'd20);
    one_cycle(1'b1, -32'sd7);
    check_done();
    collect();

    // Asynchronous reset in the middle of ACCUM after two sums.
    begin_job(1'b0, '0, 4, 1'b0);
    one_cycle(1'b1, 32'h1234_5678);
    one_cycle(1'b1, 32'h0BAD_F00D);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // N=4 with bubbles: valid pattern 1,0,1,0,1,1.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    begin_job(1'b0, '0, 4, 1'b0);
    for (int i = 0; i < 6; i++) one_cycle(pat[i], $urandom);
    check_done();
    collect();

    // Zero-length job with maximum positive bias.
    begin_job(1'b1, 32'h7FFF_FFFF, 0, 1'b0);

    // Hold result with result_ready low for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", result, 32'h7FFF_FFFF);
      check_bit("hold_valid", result_valid, 1'b1);
      @(posedge clk); #1;
    end

    // Back-to-back restart: result_ready and start together.
    begin_job(1'b0, 32'hDEAD_BEEF, 2, 1'b1);
    run_sums(1'b0);
    check_done();
    collect();

    // Flush together with start while in DONE: result is discarded.
    begin_job(1'b0, '0, 1, 1'b0);
    one_cycle(1'b1, $urandom);
    check_done();
    dropped = exp_q.pop_back();
    flush = 1'b1; start = 1'b1; use_bias = 1'b1; bias = 32'd3; num_accumulations = C'(2);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; use_bias = 1'b0; bias = '0; num_accumulations = '0;
    @(negedge clk);
    check_bit("flush_done_busy", busy, 1'b0);
    check_bit("flush_done_valid", result_valid, 1'b0);
    check("flush_done_acc_out", acc_out, '0);
    @(posedge clk); #1;

    // Flush during a sum transfer in ACCUM: the transfer is discarded.
    begin_job(1'b1, 32'd9, 3, 1'b0);
    one_cycle(1'b1, 32'd100);
    flush = 1'b1; sum_valid = 1'b1; sum = 32'hDEAD_0001;
    @(posedge clk); #1;
    flush = 1'b0; sum_valid = 1'b0; sum = '0;
    @(negedge clk);
    check_bit("flush_accum_busy", busy, 1'b0);
    check_bit("flush_accum_sum_ready", sum_ready, 1'b0);
    check_bit("flush_accum_valid", result_valid, 1'b0);
    check("flush_accum_acc_out", acc_out, '0);
    @(posedge clk); #1;
    begin_job(1'b0, '0, 2, 1'b0);
    run_sums(1'b1);
    check_done();
    collect();

    // Randomized jobs, mixing plain starts and back-to-back restarts.
    in_done = 1'b0;
    for (int j = 0; j < 30; j++) begin
      ub = 1'($urandom % 2);
      b  = $urandom;
      n  = int'($urandom_range(0, 6));
      if (in_done && ($urandom % 2 == 1)) begin
        begin_job(ub, b, n, 1'b1);
      end else begin
        if (in_done) collect();
        begin_job(ub, b, n, 1'b0);
      end
      if (n != 0) begin
        run_sums(1'b1);
        check_done();
      end
      in_done = 1'b1;
    end
    collect();

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d results never seen, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pe_accumulator
